// File: rtl/port_load_counter_if.sv
// port_load_counter_if -- processor-side bus of the port-loaded down-counter.
//
// Signals:
//   ld            processor -> counter  single-cycle load strobe (decoded port write)
//   out_port      processor -> counter  16-bit data captured when ld=1
//   interrupt_ack processor -> counter  clears a pending interrupt
//   count         counter -> processor  current count value
//   interrupt     counter -> processor  sticky terminal-count interrupt
//   running       counter -> processor  high while the counter is in RUN
//   state         counter -> processor  FSM state for debug (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: there is no valid/ready pair on this bus. ld and interrupt_ack
// are one-cycle strobes sampled on the rising clock edge; every counter-side
// signal is a registered value that is stable for the whole cycle.
interface port_load_counter_if;
    logic        ld;
    logic [15:0] out_port;
    logic        interrupt_ack;
    logic [15:0] count;
    logic        interrupt;
    logic        running;
    logic [1:0]  state;

    modport master (
        output ld,
        output out_port,
        output interrupt_ack,
        input  count,
        input  interrupt,
        input  running,
        input  state
    );

    modport slave (
        input  ld,
        input  out_port,
        input  interrupt_ack,
        output count,
        output interrupt,
        output running,
        output state
    );
endinterface

// File: rtl/port_load_counter.sv
// port_load_counter -- processor-loadable 16-bit down-counter with a clock
// prescaler and a sticky terminal-count interrupt.
//
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous, active-low reset
//   bus    port_load_counter_if.slave (ld, out_port, interrupt_ack in;
//          count, interrupt, running, state out)
//
// A load captures out_port into count and the reload register and restarts
// the prescaler. While in RUN the prescaler counts 0..PRESCALE-1; the edge
// at which it sits at PRESCALE-1 is a tick and decrements count. The tick
// that finds count == 1 is the terminal tick: it raises the interrupt and
// either reloads (AUTO_RELOAD=1) or parks the counter at 0 in DONE.
module port_load_counter #(
    parameter logic [15:0] PRESCALE    = 16'd50000,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input logic               clk,
    input logic               reset,
    port_load_counter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] PRE_LAST = PRESCALE - 16'd1;

    state_t      state_q,  state_d;
    logic [15:0] count_q,  count_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] pre_q,    pre_d;
    logic        intr_q,   intr_d;

    logic tick;
    logic terminal;

    // A load on the same edge pre-empts the tick, so a terminal tick can
    // only happen on an edge without ld.
    always_comb begin
        tick     = (state_q == RUN) && (pre_q == PRE_LAST);
        terminal = tick && (count_q == 16'd1) && !bus.ld;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= 16'h0000;
            reload_q <= 16'h0000;
            pre_q    <= 16'h0000;
            intr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            intr_q   <= intr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pre_d    = pre_q;

        if (bus.ld) begin
            count_d  = bus.out_port;
            reload_d = bus.out_port;
            pre_d    = 16'h0000;
            state_d  = (bus.out_port != 16'h0000) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick) begin
                        pre_d = 16'h0000;
                        if (count_q > 16'd1) begin
                            count_d = count_q - 16'd1;
                        end else if (count_q == 16'd1) begin
                            if (AUTO_RELOAD) begin
                                count_d = reload_q;
                            end else begin
                                count_d = 16'h0000;
                                state_d = DONE;
                            end
                        end else begin
                            // count is never 0 in RUN; park safely if it is.
                            state_d = DONE;
                        end
                    end else begin
                        pre_d = pre_q + 16'd1;
                    end
                end
                IDLE:    ;
                DONE:    ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Set wins over a coincident acknowledge; a load leaves it untouched.
    always_comb begin
        intr_d = intr_q;
        if (terminal) begin
            intr_d = 1'b1;
        end else if (bus.interrupt_ack) begin
            intr_d = 1'b0;
        end
    end

    assign bus.count     = count_q;
    assign bus.interrupt = intr_q;
    assign bus.running   = (state_q == RUN);
    assign bus.state     = state_q;

endmodule
